// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache fill
// path and the D-cache fill/writeback path. One transaction at a time:
// grant -> MEM_LATENCY busy cycles -> response held until the matching ack.
// The arbiter owns the memory latency counter, so neither cache counts cycles.
//
// Optional build macro MEM_ARB_RR_EN: when defined, simultaneous I+D requests
// alternate via a last_grant register (reset to I). When undefined, D has
// fixed priority over I.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int LINE_WIDTH  = 128,
  parameter int TAG_WIDTH   = 28,
  parameter int MEM_LATENCY = 5      // legal range 1..255
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache side
  input  logic                  reqI_mem,
  input  logic [TAG_WIDTH-1:0]  reqAddrI_mem,
  output logic [LINE_WIDTH-1:0] instr_from_mem,
  output logic                  mem_data_rdyI,
  input  logic                  data_filled_ackI,
  // D-cache side
  input  logic                  reqD_mem,
  input  logic [TAG_WIDTH-1:0]  reqAddrD_mem,
  input  logic                  reqWrD_mem,
  input  logic [LINE_WIDTH-1:0] wrDataD_mem,
  output logic [LINE_WIDTH-1:0] data_from_mem,
  output logic                  mem_data_rdyD,
  input  logic                  data_filled_ackD,
  // memory side
  output logic                  mem_req,
  output logic [TAG_WIDTH-1:0]  mem_addr,
  output logic                  mem_we,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  // Counter is loaded with MEM_LATENCY-1 on grant; the busy phase ends at the
  // edge where it reads zero, giving exactly MEM_LATENCY cycles of mem_req.
  localparam logic [7:0] LOAD_COUNT = 8'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t                r_state;
  logic [7:0]            r_count;
  logic                  r_is_wr;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [TAG_WIDTH-1:0]  r_mem_addr;
  logic [LINE_WIDTH-1:0] r_mem_wdata;
  logic [LINE_WIDTH-1:0] r_instr_line;
  logic [LINE_WIDTH-1:0] r_data_line;
  logic                  r_rdy_i;
  logic                  r_rdy_d;
`ifdef MEM_ARB_RR_EN
  logic                  r_last_grant_d;   // 0 = I granted last, 1 = D
`endif

  logic w_pick_d;
  logic w_pick_i;
  logic w_we_at_load;

  // Grant selection while IDLE; only consulted in the IDLE state.
  always_comb begin
    w_pick_d = 1'b0;
    w_pick_i = 1'b0;
`ifdef MEM_ARB_RR_EN
    // On a tie, whoever was not granted last wins.
    w_pick_d = reqD_mem && (!reqI_mem || !r_last_grant_d);
`else
    // On a tie, the data side wins: it belongs to the older instruction.
    w_pick_d = reqD_mem;
`endif
    w_pick_i = reqI_mem && !w_pick_d;
    // With a one-cycle latency the single busy cycle is also the strobe cycle.
    w_we_at_load = reqWrD_mem && (LOAD_COUNT == 8'd0);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= 8'd0;
      r_is_wr        <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_instr_line   <= '0;
      r_data_line    <= '0;
      r_rdy_i        <= 1'b0;
      r_rdy_d        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_grant_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= BUSY_D;
            r_mem_addr  <= reqAddrD_mem;
            r_mem_wdata <= wrDataD_mem;
            r_is_wr     <= reqWrD_mem;
            r_count     <= LOAD_COUNT;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_we_at_load;
`ifdef MEM_ARB_RR_EN
            r_last_grant_d <= 1'b1;
`endif
          end else if (w_pick_i) begin
            r_state    <= BUSY_I;
            r_mem_addr <= reqAddrI_mem;
            r_is_wr    <= 1'b0;
            r_count    <= LOAD_COUNT;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_grant_d <= 1'b0;
`endif
          end
        end

        BUSY_I, BUSY_D: begin
          if (r_count == 8'd0) begin
            // Final busy edge: capture the line and present the response.
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_state == BUSY_I) begin
              r_instr_line <= mem_rdata;
              r_rdy_i      <= 1'b1;
              r_state      <= RESP_I;
            end else begin
              // A writeback completes without touching the D fill line.
              if (!r_is_wr) begin
                r_data_line <= mem_rdata;
              end
              r_rdy_d <= 1'b1;
              r_state <= RESP_D;
            end
          end else begin
            r_count  <= r_count - 8'd1;
            // Strobe lands only in the last busy cycle (count reaches zero).
            r_mem_we <= r_is_wr && (r_count == 8'd1);
          end
        end

        RESP_I: begin
          if (data_filled_ackI) begin
            r_rdy_i <= 1'b0;
            r_state <= IDLE;
          end
        end

        RESP_D: begin
          if (data_filled_ackD) begin
            r_rdy_d <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_from_mem = r_instr_line;
  assign mem_data_rdyI  = r_rdy_i;
  assign data_from_mem  = r_data_line;
  assign mem_data_rdyD  = r_rdy_d;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign mem_we         = r_mem_we;
  assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed vector table, two hand
// sequences (long ack hold, reset mid-writeback) and randomized rounds checked
// against a transaction-level model of grant order, latency and line contents.
`timescale 1ns/1ps

module tb_mem_arbiter;
  localparam int LW = 128;
  localparam int TW = 28;
  localparam int L  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqI_mem, reqD_mem, reqWrD_mem;
  logic [TW-1:0] reqAddrI_mem, reqAddrD_mem;
  logic [LW-1:0] wrDataD_mem;
  logic          data_filled_ackI, data_filled_ackD;
  logic [LW-1:0] instr_from_mem, data_from_mem, mem_wdata, mem_rdata;
  logic          mem_data_rdyI, mem_data_rdyD, mem_req, mem_we;
  logic [TW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WIDTH(LW), .TAG_WIDTH(TW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
    .instr_from_mem(instr_from_mem), .mem_data_rdyI(mem_data_rdyI),
    .data_filled_ackI(data_filled_ackI),
    .reqD_mem(reqD_mem), .reqAddrD_mem(reqAddrD_mem), .reqWrD_mem(reqWrD_mem),
    .wrDataD_mem(wrDataD_mem), .data_from_mem(data_from_mem),
    .mem_data_rdyD(mem_data_rdyD), .data_filled_ackD(data_filled_ackD),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: the line content is a fixed function of its address,
  // and is garbage whenever no transaction is active.
  function automatic logic [LW-1:0] pat(input logic [TW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return {w ^ 32'hDEADBEEF, w * 32'h9E3779B1, ~w, w + 32'h01234567};
  endfunction
  assign mem_rdata = mem_req ? pat(mem_addr) : {4{32'hBAADF00D}};

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference state: expected line registers and who was granted last.
  logic [LW-1:0] exp_i_line = '0;
  logic [LW-1:0] exp_d_line = '0;
  bit            model_last_d = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, ".mem_req"}, mem_req, 1'b0);
    chk1({tag, ".mem_we"}, mem_we, 1'b0);
    chk1({tag, ".rdyI"}, mem_data_rdyI, 1'b0);
    chk1({tag, ".rdyD"}, mem_data_rdyD, 1'b0);
    chk({tag, ".mem_addr"}, LW'(mem_addr), '0);
    chk({tag, ".mem_wdata"}, mem_wdata, '0);
    chk({tag, ".instr"}, instr_from_mem, '0);
    chk({tag, ".data"}, data_from_mem, '0);
  endtask

  // Tie rule from the specification, expressed on the model's grant history.
  function automatic bit tie_winner_is_d();
`ifdef MEM_ARB_RR_EN
    return !model_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Called at the negedge just after the grant edge. Checks L busy cycles,
  // the response phase held for ack_delay extra cycles, then the ack.
  task automatic serve(input bit is_d, input logic [TW-1:0] addr, input bit wr,
                       input logic [LW-1:0] wdata, input int ack_delay);
    for (int c = 0; c < L; c++) begin
      chk1("busy.mem_req", mem_req, 1'b1);
      chk("busy.mem_addr", LW'(mem_addr), LW'(addr));
      chk1("busy.mem_we", mem_we, wr && (c == L - 1));
      if (wr) chk("busy.mem_wdata", mem_wdata, wdata);
      chk1("busy.rdyI", mem_data_rdyI, 1'b0);
      chk1("busy.rdyD", mem_data_rdyD, 1'b0);
      // Acks outside the response phase must be ignored.
      data_filled_ackI = 1'($urandom_range(0, 1));
      data_filled_ackD = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    model_last_d = is_d;
    if (!wr) begin
      if (is_d) exp_d_line = pat(addr);
      else      exp_i_line = pat(addr);
    end
    for (int c = 0; c <= ack_delay; c++) begin
      chk1("resp.mem_req", mem_req, 1'b0);
      chk1("resp.mem_we", mem_we, 1'b0);
      chk1("resp.rdyI", mem_data_rdyI, !is_d);
      chk1("resp.rdyD", mem_data_rdyD, is_d);
      chk("resp.instr", instr_from_mem, exp_i_line);
      chk("resp.data", data_from_mem, exp_d_line);
      if (c == ack_delay) begin
        if (is_d) begin
          reqD_mem = 1'b0; data_filled_ackD = 1'b1; data_filled_ackI = 1'b0;
        end else begin
          reqI_mem = 1'b0; data_filled_ackI = 1'b1; data_filled_ackD = 1'b0;
        end
      end else begin
        // The other requester's ack must not close this response.
        if (is_d) begin
          data_filled_ackD = 1'b0; data_filled_ackI = 1'($urandom_range(0, 1));
        end else begin
          data_filled_ackI = 1'b0; data_filled_ackD = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
    end
    data_filled_ackI = 1'b0;
    data_filled_ackD = 1'b0;
    chk1("idle.mem_req", mem_req, 1'b0);
    chk1("idle.rdyI", mem_data_rdyI, 1'b0);
    chk1("idle.rdyD", mem_data_rdyD, 1'b0);
    txn++;
    $display("txn %0d: %s addr=%h wr=%0d ack_delay=%0d checks=%0d errors=%0d",
             txn, is_d ? "D" : "I", addr, wr, ack_delay, checks, errors);
  endtask

  // Presents one or two simultaneous requests at an idle negedge and serves
  // them in the expected order; the loser's request is held meanwhile.
  task automatic run_pair(input bit ri, input bit rd, input bit wr,
                          input logic [TW-1:0] ai, input logic [TW-1:0] ad,
                          input logic [LW-1:0] wd, input int a1, input int a2,
                          input bit first_d);
    reqI_mem = ri; reqAddrI_mem = ai;
    reqD_mem = rd; reqAddrD_mem = ad; reqWrD_mem = wr; wrDataD_mem = wd;
    @(negedge clk);
    if (ri && rd) begin
      if (first_d) serve(1'b1, ad, wr, wd, a1);
      else         serve(1'b0, ai, 1'b0, '0, a1);
      @(negedge clk);   // one idle cycle before the waiting request is granted
      if (first_d) serve(1'b0, ai, 1'b0, '0, a2);
      else         serve(1'b1, ad, wr, wd, a2);
    end else if (rd) begin
      serve(1'b1, ad, wr, wd, a1);
    end else begin
      serve(1'b0, ai, 1'b0, '0, a1);
    end
  endtask

  typedef struct {
    bit            req_i;
    bit            req_d;
    bit            wr_d;
    logic [TW-1:0] addr_i;
    logic [TW-1:0] addr_d;
    logic [LW-1:0] wdata;
    int            ack1;
    int            ack2;
    bit            exp_first_d;   // expected first grant on a tie
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000100, 28'h0000000, {LW{1'b0}}, 0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 28'h0000010, 28'h0000020, {LW{1'b0}}, 1, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 28'h0000000, 28'h0000030, {4{32'hA5A5A5A5}}, 2, 0, 1'b1};
`ifdef MEM_ARB_RR_EN
    vecs[3] = '{1'b1, 1'b1, 1'b1, 28'h0000055, 28'h0000066, {4{32'h3C3C0FF0}}, 0, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000077, 28'h0000088, {LW{1'b0}}, 2, 3, 1'b0};
`else
    vecs[3] = '{1'b1, 1'b1, 1'b1, 28'h0000055, 28'h0000066, {4{32'h3C3C0FF0}}, 0, 1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000077, 28'h0000088, {LW{1'b0}}, 2, 3, 1'b1};
`endif

    reset = 1'b1;
    reqI_mem = 1'b0; reqD_mem = 1'b0; reqWrD_mem = 1'b0;
    reqAddrI_mem = '0; reqAddrD_mem = '0; wrDataD_mem = '0;
    data_filled_ackI = 1'b0; data_filled_ackD = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      run_pair(vecs[v].req_i, vecs[v].req_d, vecs[v].wr_d, vecs[v].addr_i,
               vecs[v].addr_d, vecs[v].wdata, vecs[v].ack1, vecs[v].ack2,
               vecs[v].exp_first_d);
    end

    // Long ack hold in RESP_I while a D request waits.
    reqI_mem = 1'b1; reqAddrI_mem = 28'h0ABCDE1;
    @(negedge clk);
    reqD_mem = 1'b1; reqAddrD_mem = 28'h0ABCDE2; reqWrD_mem = 1'b0; wrDataD_mem = '0;
    serve(1'b0, 28'h0ABCDE1, 1'b0, '0, 10);
    @(negedge clk);
    serve(1'b1, 28'h0ABCDE2, 1'b0, '0, 0);

    // Reset during the third busy cycle of a writeback.
    reqD_mem = 1'b1; reqAddrD_mem = 28'h0000031; reqWrD_mem = 1'b1;
    wrDataD_mem = {4{32'h5A5AC3C3}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("rstseq.mem_req", mem_req, 1'b1);
      chk1("rstseq.mem_we", mem_we, 1'b0);
    end
    reset = 1'b1; reqD_mem = 1'b0; reqWrD_mem = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset = 1'b0;
    exp_i_line = '0; exp_d_line = '0; model_last_d = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk1("postrst.mem_req", mem_req, 1'b0);
      chk1("postrst.mem_we", mem_we, 1'b0);
      chk1("postrst.rdyD", mem_data_rdyD, 1'b0);
    end

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int            kind;
      logic [TW-1:0] ai, ad;
      logic [LW-1:0] wd;
      bit            wr;
      int            a1, a2;
      kind = int'($urandom_range(0, 4));
      ai = TW'($urandom);
      ad = TW'($urandom);
      if (ad == ai) ad = ai ^ 28'h1;
      wd = {$urandom, $urandom, $urandom, $urandom};
      wr = 1'($urandom_range(0, 1));
      a1 = int'($urandom_range(0, 3));
      a2 = int'($urandom_range(0, 3));
      case (kind)
        0: run_pair(1'b1, 1'b0, 1'b0, ai, ad, wd, a1, a2, 1'b0);
        1: run_pair(1'b0, 1'b1, wr, ai, ad, wd, a1, a2, 1'b1);
        2: run_pair(1'b1, 1'b1, wr, ai, ad, wd, a1, a2, tie_winner_is_d());
        3: begin
          // I alone first, D arrives while I is busy.
          reqI_mem = 1'b1; reqAddrI_mem = ai;
          @(negedge clk);
          reqD_mem = 1'b1; reqAddrD_mem = ad; reqWrD_mem = wr; wrDataD_mem = wd;
          serve(1'b0, ai, 1'b0, '0, a1);
          @(negedge clk);
          serve(1'b1, ad, wr, wd, a2);
        end
        default: begin
          // D alone first, I arrives while D is busy.
          reqD_mem = 1'b1; reqAddrD_mem = ad; reqWrD_mem = wr; wrDataD_mem = wd;
          @(negedge clk);
          reqI_mem = 1'b1; reqAddrI_mem = ai;
          serve(1'b1, ad, wr, wd, a1);
          @(negedge clk);
          serve(1'b0, ai, 1'b0, '0, a2);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path (fetch stage) and the data-cache miss/writeback path.
- One transaction is in flight at a time. Each transaction has a fixed-latency memory phase, a response phase and an ack handshake.
- Sits between both caches and the memory model. It owns the latency counter, so the caches never count memory cycles.

Parameters:
- LINE_WIDTH, 128: cache line width in bits.
- TAG_WIDTH, 28: line-address width (virtual address without line offset).
- MEM_LATENCY, 5: number of cycles the memory phase lasts; legal range 1..255.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqI_mem  in  1  I-cache fill request.
- reqAddrI_mem  in  TAG_WIDTH  I-cache fill line address.
- instr_from_mem  out  LINE_WIDTH  fill line returned to the I-cache.
- mem_data_rdyI  out  1  I response valid.
- data_filled_ackI  in  1  I-cache has consumed the line.
- reqD_mem  in  1  D-cache request.
- reqAddrD_mem  in  TAG_WIDTH  D-cache line address.
- reqWrD_mem  in  1  1 = writeback, 0 = fill.
- wrDataD_mem  in  LINE_WIDTH  writeback line.
- data_from_mem  out  LINE_WIDTH  fill line returned to the D-cache.
- mem_data_rdyD  out  1  D response valid (fill data or write completion).
- data_filled_ackD  in  1  D-cache has consumed the response.
- mem_req  out  1  memory busy with a transaction.
- mem_addr  out  TAG_WIDTH  latched transaction address.
- mem_we  out  1  write strobe.
- mem_wdata  out  LINE_WIDTH  latched write data.
- mem_rdata  in  LINE_WIDTH  memory read data, valid while mem_req=1 and the address is stable.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, count=0.
  - All outputs 0, including both line registers, mem_addr and mem_wdata.
  - Reset asserted mid-transaction drops the transaction; no write strobe is issued and no rdy is raised.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Samples reqI_mem/reqD_mem each edge.
  - If only one is high, that requester is granted.
  - If both are high, D wins (older instruction), unless the optional feature is on.
  - On grant: latch the address (plus reqWrD_mem and wrDataD_mem for D), load count=MEM_LATENCY-1, go to BUSY_x.
  - Request inputs changing after the grant edge are ignored.
- BUSY_x:
  - mem_req=1; mem_addr and mem_wdata are held.
  - count decrements each edge.
  - At the edge where count==0: the read data mem_rdata is latched into the requester's line register, state goes to RESP_x.
  - For a D writeback, mem_we=1 only during the final BUSY cycle (count==0), so there is exactly one write strobe. data_from_mem keeps its previous value.
- Latency: request sampled at edge E0 gives mem_data_rdyx=1 after edge E0+MEM_LATENCY. There are exactly MEM_LATENCY cycles with mem_req=1.
- RESP_x:
  - mem_req=0; mem_data_rdyx=1 and the line register is held stable until the matching ack.
  - When data_filled_ackx is sampled high: rdy clears, state goes to IDLE.
  - An ack outside RESP_x, or an ack from the other requester, is ignored.
  - The requester must drop req in the same cycle it raises ack. A req still high in IDLE is treated as a new request.
- Back-to-back: there is one IDLE cycle between the ack edge and the next grant edge.
- A request arriving while busy waits with req held. No request is lost, and there is no queue beyond the held req.
- A request that is never acked stalls the arbiter indefinitely. No timeout.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Adds a 1-bit last_grant register, reset to I.
  - On a simultaneous I+D request in IDLE, the requester not granted last wins. last_grant updates on every grant.
- Undefined: fixed priority, D over I.

Test Plan:
- I fill alone, MEM_LATENCY=5, reqAddrI_mem=0x0000100, mem_rdata=0xDEADBEEF… → mem_req high for exactly 5 cycles with mem_addr=0x0000100; mem_data_rdyI rises after edge E0+5 with instr_from_mem=that line; ack → IDLE the next edge.
- Simultaneous I (0x10) and D (0x20) fill, macro undefined → D served first (mem_addr=0x20); I granted on the edge after ackD; total 2×(5+1)+idle cycles.
- Same stimulus with MEM_LATENCY_RR_EN… i.e. MEM_ARB_RR_EN defined, after reset (last_grant=I) → D granted first; next simultaneous pair → I granted first.
- D writeback, addr 0x30, wrDataD_mem=0xA5A5… → mem_we high for exactly 1 cycle, in the 5th BUSY cycle, with mem_wdata=0xA5A5…; mem_data_rdyD then pulses until ack; data_from_mem unchanged.
- Reset asserted in the 3rd BUSY cycle of a D writeback → next cycle all outputs 0; mem_we never asserted; no rdy raised.
- Ack held low for 10 cycles in RESP_I while reqD_mem is high → mem_data_rdyI and instr_from_mem stable; mem_req stays 0; D granted only after ackI.
